// File: rtl/counter_sequencer.sv
// Run controller for a WIDTH-bit up-counter: sequences IDLE/RUN/PAUSED/DONE,
// supports one-shot and auto-reload runs, and counts auto-reload completions.
module counter_sequencer #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              load_en,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              auto_reload,
  output logic [WIDTH-1:0]  count,
  output logic [1:0]        state,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wraps
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  localparam logic [WIDTH-1:0]  CNT_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]  TERM_RST  = {WIDTH{1'b1}};
  localparam logic [WRAP_W-1:0] WRAP_ZERO = {WRAP_W{1'b0}};
  localparam logic [WRAP_W-1:0] WRAP_ONE  = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_MAX  = {WRAP_W{1'b1}};

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    term_q, term_d;
  logic [WRAP_W-1:0]   wraps_q, wraps_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    if (v == WRAP_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + WRAP_ONE;
    end
  endfunction

  // Next-state computation: stop beats pause beats start in every state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    wraps_d = wraps_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          term_d = load_val;
        end else begin
          term_d = term_q;
        end
        if (stop || pause) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
          count_d = CNT_ZERO;
          wraps_d = WRAP_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = CNT_ZERO;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else if (count_q == term_q) begin
          done_d = 1'b1;
          if (auto_reload) begin
            count_d = CNT_ZERO;
            wraps_d = sat_inc(wraps_q);
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      ST_PAUSED: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = CNT_ZERO;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else if (start) begin
          // Resume keeps the held value; a held terminal fires on the next RUN edge.
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSED;
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = CNT_ZERO;
        end else if (pause) begin
          state_d = ST_DONE;
        end else if (start) begin
          state_d = ST_RUN;
          count_d = CNT_ZERO;
          wraps_d = WRAP_ZERO;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = CNT_ZERO;
      end
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
  end

  // State and registered outputs; reset also restores the terminal to all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= CNT_ZERO;
      term_q  <= TERM_RST;
      wraps_q <= WRAP_ZERO;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      wraps_q <= wraps_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign wraps = wraps_q;

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Run controller for the team's WIDTH-bit up-counter datapath. The counter register is internal. The block sequences it through idle, run, pause and terminal states. It counts 0..terminal and then either stops or auto-reloads, and it flags completion to surrounding logic. It sits between a command source (bench or CPU-side register block) and any logic that consumes the count value or the completion pulse.

Parameters:
WIDTH, 4, counter and terminal-value width in bits.
WRAP_W, 8, width of the saturating auto-reload completion counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
start  input  1  begin counting from 0 (IDLE/DONE) or resume (PAUSED).
stop  input  1  abort the run and return to IDLE.
pause  input  1  freeze the count while in RUN.
load_en  input  1  write load_val into the terminal register; honoured in IDLE only.
load_val  input  WIDTH  terminal value to load.
auto_reload  input  1  1 = periodic mode, 0 = one-shot. Sampled live every cycle.
count  output  WIDTH  current counter value (registered).
state  output  2  IDLE=00, RUN=01, PAUSED=10, DONE=11.
busy  output  1  high in RUN or PAUSED.
done  output  1  one-cycle completion pulse (registered).
wraps  output  WRAP_W  auto-reload completions since the last fresh start; saturates.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, count=0, terminal=all ones, done=0, busy=0, wraps=0. Deassertion is taken synchronously; the first active edge follows.
- Command priority on any edge: stop > pause > start. load_en is independent of the run commands.
- IDLE:
  - load_en=1 -> terminal<=load_val.
  - start=1 -> RUN, count<=0, wraps<=0.
  - If load_en and start are high on the same edge, the new terminal applies to that run.
- RUN:
  - Default: count<=count+1.
  - When count==terminal on an edge, the terminal event fires:
    - auto_reload=1: count<=0, done<=1, wraps<=wraps+1 (holds at all ones when saturated), remain in RUN.
    - auto_reload=0: state<=DONE, count holds terminal, done<=1.
  - stop -> IDLE, count<=0. No terminal event or done, even if count==terminal on that edge.
  - pause -> PAUSED, count holds. The terminal event is suppressed on that edge.
  - start in RUN is ignored.
- PAUSED:
  - count holds; busy stays 1.
  - start -> RUN and counting resumes from the held value. If the held value equals terminal, the terminal event fires on the next RUN edge.
  - stop -> IDLE, count<=0.
- DONE:
  - count holds terminal; busy=0.
  - start -> RUN, count<=0, wraps<=0.
  - stop -> IDLE, count<=0.
  - load_en ignored.
- done is high for exactly one cycle after each terminal event and low otherwise.
- Latency: start sampled at edge E0 gives count=0 after E0 and count=k after E0+k. The terminal event occurs at E0+terminal+1.
  - One-shot total run: terminal+1 counting cycles.
  - Auto-reload period: terminal+1 cycles between done pulses.
- terminal=0: count stays 0 and the terminal event fires on the first RUN edge. With auto_reload=1, done is high every cycle.
- Arithmetic: count never exceeds terminal, so no WIDTH overflow is possible. wraps never wraps around.
- Reset asserted mid-run: immediate return to the reset values, including terminal back to all ones.

Test Plan:
- Reset then default run: reset low for 10 ns, start pulse with auto_reload=0 -> count 0..15 on successive edges, state=DONE, done high for one cycle, count holds 15, busy=0.
- Loaded one-shot: IDLE, load_val=5 + load_en, then start -> count 0,1,2,3,4,5, then DONE with done pulse 6 cycles after start. Restart with start -> count back to 0, wraps=0.
- Auto-reload: load_val=3, auto_reload=1, start -> count 0,1,2,3,0,1... with done pulses every 4 cycles. After 300 reloads, wraps=255 (saturated).
- Pause/resume: terminal=9, pause asserted at count=4 for 5 cycles -> count holds 4 and state=PAUSED. start -> count continues 5..9, then DONE.
- Collisions:
  - Terminal=3, stop on the edge where count==3 -> IDLE, count=0, no done pulse.
  - pause on the terminal edge -> PAUSED, count=3; start -> done on the next edge.
  - start+stop together in IDLE -> stays IDLE.
- Async reset mid-run: pull reset low between clock edges while count=6 in RUN -> count=0, state=IDLE, done=0 and busy=0 immediately, without waiting for a clock edge. load_en in RUN is ignored; terminal is unchanged.
